// File: rtl/tone_pkg.sv
// Constants shared by the frequency-code lookup, note sequencer and tone divider.
package tone_pkg;

    localparam int CODE_W = 11;

    typedef logic [CODE_W-1:0] code_t;

    localparam code_t REST_CODE = 11'h7FF;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock-enable rate: TICK pulses once every PRE_DIV enabled clocks.
module tick_prescaler #(
    parameter int PRE_DIV = 1
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic EN,
    output logic TICK
);

    // With PRE_DIV=1 the counter is pinned at 0, so TICK degenerates to EN.
    localparam int PW = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRE_DIV - 1);

    logic [PW-1:0] r_pre;
    logic          w_wrap;

    assign w_wrap = (r_pre == LAST);
    assign TICK   = EN && w_wrap;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_pre <= '0;
        end else if (EN) begin
            if (w_wrap) begin
                r_pre <= '0;
            end else begin
                r_pre <= r_pre + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tone_divider.sv
// Preloadable up-counter tone generator; toggles SPKS on each overflow at 0x7FF.
// Optional macro TONE_REST_MUTE_EN silences SPKS while the rest code is in force.
module tone_divider
    import tone_pkg::*;
#(
    parameter int PRE_DIV = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              EN,
    input  logic [CODE_W-1:0] F_CODE,
    output logic              SPKS,
    output logic              FULL,
    output logic [CODE_W-1:0] CODE_Q
);

    logic  w_tick;
    logic  w_ovf;
    logic  w_spks_next;
    code_t r_cnt;
    code_t r_code;
    logic  r_spks;
    logic  r_full;

    tick_prescaler #(
        .PRE_DIV(PRE_DIV)
    ) u_pre (
        .CLK  (CLK),
        .RST_N(RST_N),
        .EN   (EN),
        .TICK (w_tick)
    );

    assign w_ovf = (r_cnt == REST_CODE);

`ifdef TONE_REST_MUTE_EN
    // Capturing the rest code parks the line low; the next real code toggles it to 1.
    assign w_spks_next = (F_CODE == REST_CODE) ? 1'b0 : ~r_spks;
`else
    assign w_spks_next = ~r_spks;
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_cnt  <= REST_CODE;
            r_code <= REST_CODE;
            r_spks <= 1'b0;
            r_full <= 1'b0;
        end else begin
            r_full <= 1'b0;
            if (w_tick) begin
                if (w_ovf) begin
                    // The new code is only taken here, so a half-period is never cut short.
                    r_cnt  <= F_CODE;
                    r_code <= F_CODE;
                    r_full <= 1'b1;
                    r_spks <= w_spks_next;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign SPKS   = r_spks;
    assign FULL   = r_full;
    assign CODE_Q = r_code;

endmodule

// File: doc/tone_divider.md
# tone_divider

Programmable tone generator directly downstream of the note-index-to-frequency-code lookup. It takes the 11-bit frequency code `F_CODE` and runs a preloadable counter from that code up to 0x7FF. It toggles the speaker line on every counter overflow, so the output square wave has a pitch set by the code. Code 0x7FF marks a rest (silence).

## Interface
- `PRE_DIV`, default 1: prescale ratio; the main counter advances once every `PRE_DIV` clocks. Legal range 1..4096.
- `CLK` input, 1 bit: single system clock; all state is updated on the rising edge.
- `RST_N` input, 1 bit: reset, **synchronous, active-low**.
- `EN` input, 1 bit: run enable. When low, all counters and outputs hold.
- `F_CODE` input, 11 bits: frequency code from the lookup stage. Sampled only at reload.
- `SPKS` output, 1 bit: speaker square wave.
- `FULL` output, 1 bit: one-cycle pulse on each counter overflow/reload.
- `CODE_Q` output, 11 bits: code currently in force (the last sampled `F_CODE`).

## Operation
- **Prescaler.**
  - Counter `pre` runs 0..`PRE_DIV`-1 while `EN`=1.
  - `tick` = (`pre` == `PRE_DIV`-1) && `EN`.
  - When `PRE_DIV`=1, `tick` = `EN`.
- **Main counter `cnt`** (11 bits), evaluated on each `tick`:
  - If `cnt` == 0x7FF: `cnt` <= `F_CODE`, `CODE_Q` <= `F_CODE`, `FULL` <= 1, `SPKS` <= ~`SPKS`.
  - Otherwise: `cnt` <= `cnt` + 1 and `FULL` <= 0.
- **Cycles without a tick:** `FULL` <= 0; `cnt`, `SPKS` and `CODE_Q` hold.
- **Arithmetic.**
  - The increment is modulo 2^11, but 0x7FF always reloads and never wraps.
  - The output period is 2·(0x800 − `CODE_Q`)·`PRE_DIV` clocks.
  - `F_CODE`=0x000 gives the longest period; 0x7FF gives a period of 1 tick between overflows.
- **Code change mid-period.** A new `F_CODE` value has no effect until the next reload. Tones therefore always complete a half-period cleanly (glitch-free).
- **EN low.**
  - `pre`, `cnt`, `SPKS` and `CODE_Q` freeze, and `FULL` is 0.
  - On `EN` returning to 1, counting resumes from the frozen values with no extra reload.
- **Reset.** Applies when `RST_N`=0 at a rising edge, overrides `EN`, and may arrive mid-period. Reset values:
  - `pre`=0
  - `cnt`=0x7FF
  - `CODE_Q`=0x7FF
  - `SPKS`=0
  - `FULL`=0
- **After reset:** the first tick reloads from `F_CODE`.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reload latency: `F_CODE` is captured on the clock edge that processes the overflow tick. `CODE_Q`, `FULL` and `SPKS` change on that same edge.
- `FULL` is high for exactly one clock per overflow, even when `PRE_DIV`=1 and overflows occur on consecutive clocks.
- `PRE_DIV`=1 with `F_CODE`=0x7FD: reload to 0x7FD, then 0x7FE, then 0x7FF, then reload. `FULL` pulses every 3 clocks.
- First tick after reset release with `EN`=1 occurs `PRE_DIV` clocks later; it is a reload.

## Configuration
- **`TONE_REST_MUTE_EN` defined:**
  - A reload that captures 0x7FF forces `SPKS` to 0 and keeps it at 0 for as long as `CODE_Q`=0x7FF.
  - `FULL` still pulses normally.
  - The next reload with a non-rest code resumes toggling, starting from `SPKS`=0 and going to 1.
- **Not defined:** 0x7FF is treated as an ordinary code, and `SPKS` toggles every tick (the maximum-rate tone).

## Structure
- **Shared package `tone_pkg`:**
  - `CODE_W` = 11
  - `REST_CODE` = 11'h7FF
  - typedef `code_t` = logic [`CODE_W`-1:0]
- These constants are also shared by the frequency-code lookup and the note sequencer.
- **Sub-module `tick_prescaler`:** parameter `PRE_DIV`; ports `CLK`, `RST_N`, `EN`, `TICK`. It is reused by the note-duration timer.

## Test plan
- **Reset:** hold `RST_N`=0 for 3 clocks with `EN`=1 and `F_CODE`=0x400 → `SPKS`=0, `FULL`=0, `CODE_Q`=0x7FF throughout. The first tick after release reloads 0x400.
- **Period:** `PRE_DIV`=1, `F_CODE`=0x7FC → `FULL` pulses every 4 clocks and `SPKS` period is 8 clocks. With `PRE_DIV`=4 → `FULL` every 16 clocks.
- **Mid-period change:** `F_CODE` changes from 0x7F0 to 0x7F8 mid-count → the current period completes at 16 ticks, then the following periods are 8 ticks. `CODE_Q` updates only on the `FULL` edge.
- **EN freeze:** drop `EN` for 10 clocks mid-count → `cnt`/`SPKS` are unchanged and `FULL`=0. On resume, the remaining count finishes with no lost or extra ticks.
- **Rest code:** `F_CODE`=0x7FF with the macro defined → `SPKS` stays 0 and `FULL` pulses every tick. Without the macro → `SPKS` toggles every tick.
- **Reset mid-period:** assert `RST_N`=0 for one clock at `cnt`=0x7FA → all reset values are restored on that edge and the next tick reloads.
